// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the HI/LO multiply/divide unit.
// Op codes, FSM states, divide iteration count and operand helpers.
package muldiv_pkg;

  localparam int DIV_ITERS = 32;
  localparam int CNT_W = $clog2(DIV_ITERS);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV_RUN,
    DIV_FIX,
    DONE
  } state_e;

  function automatic logic op_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic [31:0] mag(
    input logic [31:0] v,
    input logic s
  );
    return (s && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/div_radix2.sv
// div_radix2: restoring radix-2 divider datapath, one bit per step.
// Loads magnitudes on start; quotient/remainder valid after 32 steps.
module div_radix2 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] q_r;
  logic [31:0] r_r;
  logic [31:0] d_r;
  logic [32:0] trial;
  logic [32:0] diff;

  // shift next dividend bit into the partial remainder, trial-subtract
  always_comb begin
    trial = {r_r, q_r[31]};
    diff  = trial - {1'b0, d_r};
  end

  // load on start, restore or keep the difference on each step
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= '0;
      r_r <= '0;
      d_r <= '0;
    end else if (start) begin
      q_r <= dividend;
      r_r <= '0;
      d_r <= divisor;
    end else if (step) begin
      r_r <= diff[32] ? trial[31:0] : diff[31:0];
      q_r <= {q_r[30:0], ~diff[32]};
    end
  end

  assign quotient  = q_r;
  assign remainder = r_r;

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle MULT/MULTU/DIV/DIVU unit writing HI/LO.
// Holds the pipeline while busy and pulses done/hilo_we on completion.
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [1:0]  hilo_we,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        a_r;
  logic [31:0]        b_r;
  logic [1:0]         op_r;
  logic               done_r;
  logic [1:0]         we_r;

  logic               accept;
  logic               div_start;
  logic               s_r;
  logic [63:0]        ax;
  logic [63:0]        bx;
  logic [63:0]        prod;
  logic [31:0]        quo;
  logic [31:0]        rem;
  logic [31:0]        q_fix;
  logic [31:0]        r_fix;
  logic [31:0]        res_hi;
  logic [31:0]        res_lo;

  // stall only sees state and handshake inputs, never the operands
  always_comb begin
    accept = (state == IDLE) && op_valid && !flush;
    stall  = accept
          || (state == MUL)
          || (state == DIV_RUN)
          || (state == DIV_FIX);
  end

  // an annulled op must never be seen writing HI/LO
  always_comb begin
    done    = done_r && !flush;
    hilo_we = flush ? 2'b00 : we_r;
  end

  // operand magnitudes go straight into the divider at accept
  always_comb begin
    div_start = accept && op[1] && (b != 32'd0);
  end

  div_radix2 u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .step      (state == DIV_RUN),
    .dividend  (mag(a, op_signed(op))),
    .divisor   (mag(b, op_signed(op))),
    .quotient  (quo),
    .remainder (rem)
  );

  // product and sign-fixed quotient/remainder, muxed by latched op
  always_comb begin
    s_r   = op_signed(op_r);
    ax    = {{32{s_r & a_r[31]}}, a_r};
    bx    = {{32{s_r & b_r[31]}}, b_r};
    prod  = ax * bx;
    q_fix = (s_r && (a_r[31] ^ b_r[31])) ? -quo : quo;
    r_fix = (s_r && a_r[31]) ? -rem : rem;
    if (op_r[1]) begin
      res_hi = r_fix;
      res_lo = q_fix;
    end else begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end
  end

  // control FSM with registered result and strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      op_r   <= '0;
      done_r <= 1'b0;
      we_r   <= 2'b00;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      done_r <= 1'b0;
      we_r   <= 2'b00;
      if (flush) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (op_valid) begin
              a_r  <= a;
              b_r  <= b;
              op_r <= op;
              cnt  <= '0;
              if (!op[1]) begin
                state <= MUL;
              end else if (b == 32'd0) begin
                state  <= DONE;
                done_r <= 1'b1;
                we_r   <= 2'b11;
                hi_out <= a;
                lo_out <= 32'hFFFF_FFFF;
              end else begin
                state <= DIV_RUN;
              end
            end
          end
          MUL, DIV_FIX: begin
            state  <= DONE;
            done_r <= 1'b1;
            we_r   <= 2'b11;
            hi_out <= res_hi;
            lo_out <= res_lo;
          end
          DIV_RUN: begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(DIV_ITERS - 1)) begin
              state <= DIV_FIX;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: op_valid  in  1  E-stage holds a MULT/MULTU/DIV/DIVU.
REQ-004 SHALL have: op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have: a  in  32  rs operand (dividend / multiplicand).
REQ-006 SHALL have: b  in  32  rt operand (divisor / multiplier).
REQ-007 SHALL have: flush  in  1  annul in-flight operation (exception/branch flush).
REQ-008 SHALL have: stall  out  1  hold pipeline while operation busy.
REQ-009 SHALL have: done  out  1  one-cycle result-valid pulse.
REQ-010 SHALL have: hilo_we  out  2  {hi,lo} write enables, same encoding as decoder hilo_we.
REQ-011 SHALL have: hi_out, lo_out  out  32 each  result for HI/LO, valid when done=1.

Function
REQ-012 SHALL implement states IDLE, MUL, DIV_RUN, DIV_FIX, DONE.
REQ-013 IDLE: op_valid=1 and flush=0 -> accept (cycle 0); stall=1 combinationally in cycle 0; latch a, b, op.
REQ-014 Accept MULT/MULTU -> MUL; registered 64-bit product (signed for MULT, unsigned for MULTU); next cycle -> DONE; done at cycle 2.
REQ-015 Accept DIV/DIVU with b!=0 -> DIV_RUN; signed ops divide magnitudes; 32 restoring radix-2 iterations, one per cycle, counter 0..31.
REQ-016 DIV_FIX (1 cycle): quotient negated iff signs of a,b differ (signed only); remainder takes sign of a; then DONE; done at cycle 34.
REQ-017 Accept DIV/DIVU with b==0 -> DONE next cycle (done at cycle 1); HI=a, LO=0xFFFFFFFF.
REQ-018 Signed 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0, normal latency.
REQ-019 Result mapping: MUL HI=product[63:32], LO=product[31:0]; DIV HI=remainder, LO=quotient.
REQ-020 stall=1 in cycle 0 and every cycle in MUL/DIV_RUN/DIV_FIX; stall=0 in DONE and IDLE.
REQ-021 DONE: done=1, hilo_we=2'b11 for exactly one cycle; op_valid ignored; next state IDLE.
REQ-022 Next op earliest accepted in cycle after DONE (back-to-back supported, no bubble beyond DONE).
REQ-023 flush=1 in any state: next state IDLE; no done/hilo_we in that cycle or later for annulled op; flush in IDLE blocks acceptance.
REQ-024 hi_out/lo_out SHALL hold last result until next DONE.

Reset
REQ-025 rst=1 at rising edge: state IDLE, counter 0, stall=0, done=0, hilo_we=2'b00, hi_out=lo_out=0, latched operands 0.
REQ-026 rst mid-operation SHALL abandon it with no hilo_we pulse; rst overrides flush and op_valid.

Structure
REQ-027 Op encodings, state enum and DIV_ITERS=32 SHALL live in shared package muldiv_pkg.
REQ-028 Iterative divide step/remainder register SHALL be sub-module div_radix2 (start, step, quotient, remainder); multiplier and FSM stay in muldiv_ctrl.
REQ-029 No combinational path from a/b to stall; stall depends only on state, op_valid, flush.

Verification
REQ-030 DIV a=0xFFFFFFF9 (-7), b=2 -> stall high cycles 0..33, done at 34 with LO=0xFFFFFFFD, HI=0xFFFFFFFF, hilo_we=11.
REQ-031 DIVU a=100, b=7 -> done at 34, LO=14, HI=2; then MULTU a=0xFFFFFFFF, b=2 accepted next cycle -> done 2 cycles later, HI=1, LO=0xFFFFFFFE; MULT same operands -> HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-032 DIV a=5, b=0 -> done at cycle 1, HI=5, LO=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-033 DIV started, flush at cycle 10 -> IDLE at cycle 11, stall=0, no done/hilo_we; new DIVU 9/3 at cycle 11 -> LO=3, HI=0 at cycle 45.
REQ-034 rst at cycle 20 of DIV -> all outputs reset next cycle, no hilo_we ever; flush and op_valid asserted together in IDLE -> nothing accepted.
